// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared 32-bit ALU, with an operand
// register (stage 1) and a result register (stage 2) tagged by requester id.
module alu_arbiter #(
  parameter int PRIO_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [31:0] srca0,
  input  logic [31:0] srcb0,
  input  logic [2:0]  ctl0,
  input  logic [4:0]  shamt0,
  input  logic        req1,
  input  logic [31:0] srca1,
  input  logic [31:0] srcb1,
  input  logic [2:0]  ctl1,
  input  logic [4:0]  shamt1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] result,
  output logic        zero,
  output logic        busy
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic        ptr_q, ptr_d;
  logic        s1_valid_q, s1_valid_d;
  logic        s1_id_q, s1_id_d;
  logic [31:0] s1_srca_q, s1_srca_d;
  logic [31:0] s1_srcb_q, s1_srcb_d;
  logic [2:0]  s1_ctl_q, s1_ctl_d;
  logic [4:0]  s1_shamt_q, s1_shamt_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic [31:0] alu_y;
  logic        xfer;

  // ptr only breaks ties; in fixed-priority mode requester 0 always wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      if (PRIO_MODE == 0 && ptr_q) gnt1 = 1'b1;
      else                         gnt0 = 1'b1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  assign xfer = gnt0 | gnt1;

  always_comb begin
    ptr_d      = ptr_q;
    s1_valid_d = xfer;
    s1_id_d    = s1_id_q;
    s1_srca_d  = s1_srca_q;
    s1_srcb_d  = s1_srcb_q;
    s1_ctl_d   = s1_ctl_q;
    s1_shamt_d = s1_shamt_q;
    if (xfer) begin
      ptr_d      = gnt0;
      s1_id_d    = gnt1;
      s1_srca_d  = gnt1 ? srca1  : srca0;
      s1_srcb_d  = gnt1 ? srcb1  : srcb0;
      s1_ctl_d   = gnt1 ? ctl1   : ctl0;
      s1_shamt_d = gnt1 ? shamt1 : shamt0;
    end
  end

  // Shifts act on operand B; SLT is an unsigned compare.
  always_comb begin
    alu_y = 32'h0;
    case (s1_ctl_q)
      OP_AND:  alu_y = s1_srca_q & s1_srcb_q;
      OP_OR:   alu_y = s1_srca_q | s1_srcb_q;
      OP_ADD:  alu_y = s1_srca_q + s1_srcb_q;
      OP_XOR:  alu_y = s1_srca_q ^ s1_srcb_q;
      OP_SLL:  alu_y = s1_srcb_q << s1_shamt_q;
      OP_SRL:  alu_y = s1_srcb_q >> s1_shamt_q;
      OP_SUB:  alu_y = s1_srca_q - s1_srcb_q;
      OP_SLT:  alu_y = {31'h0, (s1_srca_q < s1_srcb_q)};
      default: alu_y = 32'h0;
    endcase
  end

  always_comb begin
    result_d  = result_q;
    zero_d    = zero_q;
    rvalid0_d = s1_valid_q & ~s1_id_q;
    rvalid1_d = s1_valid_q &  s1_id_q;
    if (s1_valid_q) begin
      result_d = alu_y;
      zero_d   = (alu_y == 32'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s1_srca_q  <= 32'h0;
      s1_srcb_q  <= 32'h0;
      s1_ctl_q   <= 3'b000;
      s1_shamt_q <= 5'h0;
      result_q   <= 32'h0;
      zero_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_srca_q  <= s1_srca_d;
      s1_srcb_q  <= s1_srcb_d;
      s1_ctl_q   <= s1_ctl_d;
      s1_shamt_q <= s1_shamt_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign busy    = s1_valid_q | rvalid0_q | rvalid1_q;

endmodule
